// File: rtl/seq_pkg.sv
// Shared definitions for the serial pattern generator.
// Holds the FSM state encoding and the default maximum pattern length.
// Encodings outside the enum are treated as IDLE by the FSM.
package seq_pkg;

  // Default maximum pattern length in bits.
  localparam int SEQ_MAX_LEN = 8;

  // FSM state encoding; 2'b11 is unused and recovers to IDLE.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/sequence_generator.sv
// Serial pattern generator: emits len bits of pattern MSB-first, reps times back-to-back, then a done pulse.
// Latency: first bit on out one cycle after the accepting start edge; repetitions have no gap; one DONE cycle.
// Backpressure: none; start is sampled only in IDLE, abort cancels an emission in SHIFT without done.
// Ports:
//   clk, rst_n            clock and asynchronous active-low reset
//   start, abort          begin an emission (IDLE only) / cancel an emission (SHIFT only)
//   pattern, len, reps    pattern bits, bit count (clamped to MAX_LEN), repetitions (0 means 1)
//   out, out_valid        serial data bit and its qualifier (out is 0 when not valid)
//   busy, done            high outside IDLE / one-cycle pulse after the final bit
module sequence_generator
  import seq_pkg::*;
#(
  parameter int MAX_LEN = SEQ_MAX_LEN,
  parameter int LEN_W   = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               abort,
  input  logic [MAX_LEN-1:0] pattern,
  input  logic [LEN_W-1:0]   len,
  input  logic [LEN_W-1:0]   reps,
  output logic               out,
  output logic               out_valid,
  output logic               busy,
  output logic               done
);

  localparam int IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

  state_e             state_q, state_d;
  logic [MAX_LEN-1:0] pattern_q, pattern_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  // Index of the first bit of each repetition (clamped len - 1).
  logic [IDX_W-1:0]   last_idx_q, last_idx_d;
  // Repetitions still to run after the current one.
  logic [LEN_W-1:0]   reps_left_q, reps_left_d;

  logic [31:0]        len_ext;
  logic [31:0]        len_clamp;

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      pattern_q   <= '0;
      idx_q       <= '0;
      last_idx_q  <= '0;
      reps_left_q <= '0;
    end else begin
      state_q     <= state_d;
      pattern_q   <= pattern_d;
      idx_q       <= idx_d;
      last_idx_q  <= last_idx_d;
      reps_left_q <= reps_left_d;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d     = state_q;
    pattern_d   = pattern_q;
    idx_d       = idx_q;
    last_idx_d  = last_idx_q;
    reps_left_d = reps_left_q;

    len_ext   = 32'(len);
    len_clamp = (len_ext > 32'(MAX_LEN)) ? 32'(MAX_LEN) : len_ext;

    case (state_q)
      IDLE: begin
        // len == 0 is a no-op request; abort has no meaning here.
        if (start && (len != '0)) begin
          state_d     = SHIFT;
          pattern_d   = pattern;
          last_idx_d  = IDX_W'(len_clamp - 32'd1);
          idx_d       = IDX_W'(len_clamp - 32'd1);
          reps_left_d = (reps == '0) ? '0 : reps - LEN_W'(1);
        end
      end
      SHIFT: begin
        if (abort) begin
          state_d = IDLE;
        end else if (idx_q == '0) begin
          if (reps_left_q != '0) begin
            // Wrap straight into the next repetition, no idle cycle.
            idx_d       = last_idx_q;
            reps_left_d = reps_left_q - LEN_W'(1);
          end else begin
            state_d = DONE;
          end
        end else begin
          idx_d = idx_q - IDX_W'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Moore outputs decoded from registered state only.
  always_comb begin
    out_valid = (state_q == SHIFT);
    out       = out_valid & pattern_q[idx_q];
    busy      = (state_q != IDLE);
    done      = (state_q == DONE);
  end

endmodule
